pipelined_ctrl_stage: RTL and testbench

- Next-generation control block for the RV32 pipeline.
- Decodes the ID-stage instruction fields into the full control bundle, including jumps, LUI/AUIPC and illegal-opcode detection.
- Registers the bundle into the ID/EX boundary and applies stall and flush (bubble) rules.
- Sequences multi-cycle MUL/DIV occupancy of EX with a latency counter and an ID stall request.

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/ctrl_decoder.sv | 131 +++++++++++++
 rtl/pipelined_ctrl_stage.sv | 152 +++++++++++++++
 tb/tb_pipelined_ctrl_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the RV32 ID/EX control stage.
//   - opcode constants, ALU control codes, multi-cycle latency defaults
//   - ctrl_bundle_t: decoded control bundle carried across ID/EX
//   - muldiv_state_t: occupancy state of EX for multi-cycle MUL/DIV
package ctrl_pkg;

    localparam int unsigned ALU_CTRL_W  = 5;
    localparam int unsigned MUL_LAT_DEF = 3;
    localparam int unsigned DIV_LAT_DEF = 33;
    localparam int unsigned CNT_W_DEF   = 6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(9);
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(10);
    // MUL..REMU occupy 16..23; the low three bits are funct3
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL   = ALU_CTRL_W'(16);

    typedef struct packed {
        logic                  reg_write;
        logic                  alu_src;
        logic                  mem_write;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic                  branch;
        logic                  jump;
        logic                  jalr;
        logic                  auipc;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  illegal;
    } ctrl_bundle_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } muldiv_state_t;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: purely combinational RV32I(+M) control decode.
//   in : opcode[6:0], funct3[2:0], funct7[6:0]
//   out: ctrl (ctrl_bundle_t); is_mul / is_div only when RV32M_EN is defined
// Undecodable encodings yield an all-zero bundle with illegal=1.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
`ifdef RV32M_EN
    output logic         is_mul,
    output logic         is_div,
`endif
    output ctrl_bundle_t ctrl
);

    logic bad;
    logic mul_c;
    logic div_c;

    // Field decode; any undefined combination raises bad and is scrubbed below
    always_comb begin
        ctrl  = '0;
        bad   = 1'b0;
        mul_c = 1'b0;
        div_c = 1'b0;
        unique case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000:  ctrl.alu_control = ALU_ADD;
                        3'b001:  ctrl.alu_control = ALU_SLL;
                        3'b010:  ctrl.alu_control = ALU_SLT;
                        3'b011:  ctrl.alu_control = ALU_SLTU;
                        3'b100:  ctrl.alu_control = ALU_XOR;
                        3'b101:  ctrl.alu_control = ALU_SRL;
                        3'b110:  ctrl.alu_control = ALU_OR;
                        default: ctrl.alu_control = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    ctrl.alu_control = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ctrl.alu_control = ALU_SRA;
`ifdef RV32M_EN
                end else if (funct7 == F7_MULDIV) begin
                    ctrl.alu_control = ALU_MUL | ALU_CTRL_W'(funct3);
                    mul_c = ~funct3[2];
                    div_c = funct3[2];
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                unique case (funct3)
                    3'b000: ctrl.alu_control = ALU_ADD;
                    3'b010: ctrl.alu_control = ALU_SLT;
                    3'b011: ctrl.alu_control = ALU_SLTU;
                    3'b100: ctrl.alu_control = ALU_XOR;
                    3'b110: ctrl.alu_control = ALU_OR;
                    3'b111: ctrl.alu_control = ALU_AND;
                    3'b001: begin
                        ctrl.alu_control = ALU_SLL;
                        bad = (funct7 != F7_BASE);
                    end
                    default: begin
                        // SRLI/SRAI: only funct7[5] may be set
                        ctrl.alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
                        bad = ({funct7[6], funct7[4:0]} != 6'b0);
                    end
                endcase
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                bad = funct3[2] || (funct3 == 3'b011);
            end
            OP_BRANCH: begin
                // operands are compared by subtraction
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            OP_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.jalr      = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OP_LUI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_PASSB;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.auipc     = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            mul_c        = 1'b0;
            div_c        = 1'b0;
        end
    end

`ifdef RV32M_EN
    assign is_mul = mul_c;
    assign is_div = div_c;
`endif

endmodule

// File: rtl/pipelined_ctrl_stage.sv
// pipelined_ctrl_stage: ID decode + ID/EX control register with stall/flush,
// plus multi-cycle MUL/DIV occupancy sequencing of EX.
//   in : clk, rst (async, active high), id_valid, opcode, funct3, funct7, stall, flush
//   out: ex_valid, ex_* controls, ex_alu_control, ex_illegal (registered),
//        muldiv_busy (registered), id_stall_req (combinational)
// Macro RV32M_EN enables the M extension decode and the BUSY sequencer;
// without it muldiv_busy and id_stall_req are tied low.
module pipelined_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_alu_src,
    output logic                  ex_mem_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_jalr,
    output logic                  ex_auipc,
    output logic [ALU_CTRL_W-1:0] ex_alu_control,
    output logic                  ex_illegal,
    output logic                  muldiv_busy,
    output logic                  id_stall_req
);

    localparam int unsigned LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;

    // Reject latency settings the counter cannot represent
    if (MUL_LAT < 1 || DIV_LAT < 1 || (2 ** CNT_W) <= LAT_MAX) begin : g_bad_lat
        $error("pipelined_ctrl_stage: invalid MUL_LAT/DIV_LAT/CNT_W");
    end

    ctrl_bundle_t dec;
    ctrl_bundle_t ex_ctrl;

    assign ex_reg_write   = ex_ctrl.reg_write;
    assign ex_alu_src     = ex_ctrl.alu_src;
    assign ex_mem_write   = ex_ctrl.mem_write;
    assign ex_mem_read    = ex_ctrl.mem_read;
    assign ex_mem_to_reg  = ex_ctrl.mem_to_reg;
    assign ex_branch      = ex_ctrl.branch;
    assign ex_jump        = ex_ctrl.jump;
    assign ex_jalr        = ex_ctrl.jalr;
    assign ex_auipc       = ex_ctrl.auipc;
    assign ex_alu_control = ex_ctrl.alu_control;
    assign ex_illegal     = ex_ctrl.illegal;

`ifdef RV32M_EN
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

    logic          is_mul;
    logic          is_div;
    muldiv_state_t state;
    logic [CNT_W-1:0] cnt;
    logic          flush_pending;
    logic          hold_busy_c;
    logic          flush_eff_c;
    logic          capture_c;
    logic          long_op_c;

    ctrl_decoder u_dec (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .is_mul (is_mul),
        .is_div (is_div),
        .ctrl   (dec)
    );

    // BUSY with cycles still to run: EX frozen, ID held
    assign hold_busy_c = (state == ST_BUSY) && (cnt != '0);
    // flush_pending is only ever set while BUSY and replays on exit
    assign flush_eff_c = flush | flush_pending;
    assign capture_c   = !flush_eff_c && !stall && id_valid;
    assign long_op_c   = capture_c && ((is_mul && (MUL_LAT > 1)) || (is_div && (DIV_LAT > 1)));

    assign id_stall_req = hold_busy_c || ((state == ST_IDLE) && long_op_c);

    // ID/EX register and MUL/DIV occupancy FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            flush_pending <= 1'b0;
            muldiv_busy   <= 1'b0;
            ex_valid      <= 1'b0;
            ex_ctrl       <= '0;
        end else if (hold_busy_c) begin
            cnt <= cnt - CNT_W'(1);
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end else begin
            // IDLE, or BUSY finishing this cycle: normal capture rules
            state         <= ST_IDLE;
            flush_pending <= 1'b0;
            muldiv_busy   <= 1'b0;
            if (flush_eff_c || (!stall && !id_valid)) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
            end else if (!stall) begin
                ex_valid <= 1'b1;
                ex_ctrl  <= dec;
                if (long_op_c) begin
                    state       <= ST_BUSY;
                    cnt         <= is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
                    muldiv_busy <= 1'b1;
                end
            end
        end
    end
`else
    ctrl_decoder u_dec (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .ctrl   (dec)
    );

    assign muldiv_busy  = 1'b0;
    assign id_stall_req = 1'b0;

    // ID/EX register: flush beats stall, stall holds, invalid ID inserts a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (flush || (!stall && !id_valid)) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (!stall) begin
            ex_valid <= 1'b1;
            ex_ctrl  <= dec;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_ctrl_stage.sv
// Self-checking bench for pipelined_ctrl_stage; the M-extension scenarios
// are compiled only when RV32M_EN is defined.
module tb_pipelined_ctrl_stage;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;
    localparam int CNT_W   = 6;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall;
    logic       flush;
    logic       ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read;
    logic       ex_mem_to_reg, ex_branch, ex_jump, ex_jalr, ex_auipc;
    logic [4:0] ex_alu_control;
    logic       ex_illegal, muldiv_busy, id_stall_req;

    pipelined_ctrl_stage #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_auipc(ex_auipc),
        .ex_alu_control(ex_alu_control), .ex_illegal(ex_illegal),
        .muldiv_busy(muldiv_busy), .id_stall_req(id_stall_req)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: expected EX word, remaining busy cycles, pending flush
    logic [15:0] m_ex   = '0;
    int          m_occ  = 0;
    bit          m_pend = 1'b0;

    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    // Word layout: {valid, rw, src, mw, mr, m2r, br, j, jr, au, alu[4:0], ill}
    function automatic logic [15:0] obs_word();
        return {ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg,
                ex_branch, ex_jump, ex_jalr, ex_auipc, ex_alu_control, ex_illegal};
    endfunction

    // Expected EX word for a captured instruction, straight from the ISA tables
    function automatic logic [15:0] exp_word(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7);
        bit rw = 0, src = 0, mw = 0, mr = 0, m2r = 0, br = 0, j = 0, jr = 0, au = 0, ill = 0;
        int alu = 0;
        int r_alu [8];
        int i_alu [8];
        r_alu = '{0, 5, 8, 9, 4, 6, 3, 2};
        i_alu = '{0, 5, 8, 9, 4, 6, 3, 2};
        case (op)
            7'b0110011: begin
                rw = 1;
                if (f7 == 7'h00) alu = r_alu[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
                else if (f7 == 7'h20 && f3 == 3'd5) alu = 7;
                else if (f7 == 7'h01 && M_EN) alu = 16 + int'(f3);
                else ill = 1;
            end
            7'b0010011: begin
                rw = 1; src = 1; alu = i_alu[f3];
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) alu = 7;
                    else if (f7 != 7'h00) ill = 1;
                end
            end
            7'b0000011: begin
                rw = 1; src = 1; mr = 1; m2r = 1;
                ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'b0100011: begin src = 1; mw = 1; ill = (f3 > 3'd2); end
            7'b1100011: begin br = 1; alu = 1; ill = (f3 == 3'd2 || f3 == 3'd3); end
            7'b1101111: begin rw = 1; j = 1; end
            7'b1100111: begin rw = 1; src = 1; j = 1; jr = 1; ill = (f3 != 3'd0); end
            7'b0110111: begin rw = 1; src = 1; alu = 10; end
            7'b0010111: begin rw = 1; src = 1; au = 1; end
            default: ill = 1;
        endcase
        if (ill) return 16'h8001;
        return {1'b1, rw, src, mw, mr, m2r, br, j, jr, au, 5'(alu), 1'b0};
    endfunction

    function automatic int lat_of(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (!M_EN || op != 7'b0110011 || f7 != 7'h01) return 0;
        return f3[2] ? DIV_LAT : MUL_LAT;
    endfunction

    function automatic logic exp_stall_req();
        return (m_occ > 1) ||
               (m_occ == 0 && !flush && !stall && id_valid && lat_of(opcode, funct3, funct7) > 1);
    endfunction

    // One rising edge of the reference pipeline
    task automatic model_edge();
        bit fl;
        if (m_occ > 1) begin
            m_occ--;
            if (flush) m_pend = 1;
            return;
        end
        m_occ  = 0;
        fl     = flush || m_pend;
        m_pend = 0;
        if (fl) m_ex = '0;
        else if (!stall) begin
            if (!id_valid) m_ex = '0;
            else begin
                m_ex = exp_word(opcode, funct3, funct7);
                if (lat_of(opcode, funct3, funct7) > 1) m_occ = lat_of(opcode, funct3, funct7);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic st, input logic fl);
        id_valid = v; opcode = op; funct3 = f3; funct7 = f7; stall = st; flush = fl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 7'b0110011, 3'd0, 7'h00, 0, 0);
        tick(); tick();
        n_cmp++;
        if (obs_word() !== 16'h0) begin
            n_bad++; $display("FAIL reset_bundle: got %h want %h", obs_word(), 16'h0);
        end
        n_cmp++;
        if ({muldiv_busy, id_stall_req} !== 2'b00) begin
            n_bad++; $display("FAIL reset_busy_stall: got %b want 00", {muldiv_busy, id_stall_req});
        end
        rst = 1'b0;
    endtask

    task automatic test_rtype_add_sub();
        drive(1, 7'b0110011, 3'd0, 7'h00, 0, 0);
        tick();
        n_cmp++;
        if ({ex_valid, ex_reg_write, ex_alu_src, ex_alu_control} !== {3'b110, 5'd0}) begin
            n_bad++; $display("FAIL add_ctrl: got v/rw/src/alu %b/%b/%b/%0d want 1/1/0/0",
                              ex_valid, ex_reg_write, ex_alu_src, ex_alu_control);
        end
        drive(1, 7'b0110011, 3'd0, 7'h20, 0, 0);
        tick();
        n_cmp++;
        if ({ex_valid, ex_reg_write, ex_alu_src, ex_alu_control} !== {3'b110, 5'd1}) begin
            n_bad++; $display("FAIL sub_ctrl: got v/rw/src/alu %b/%b/%b/%0d want 1/1/0/1",
                              ex_valid, ex_reg_write, ex_alu_src, ex_alu_control);
        end
    endtask

    task automatic test_illegal();
        drive(1, 7'b1111111, 3'd0, 7'h00, 0, 0);
        tick();
        n_cmp++;
        if ({ex_illegal, ex_valid, ex_reg_write, ex_mem_write} !== 4'b1100) begin
            n_bad++; $display("FAIL illegal_opcode: got ill/v/rw/mw %b want 1100",
                              {ex_illegal, ex_valid, ex_reg_write, ex_mem_write});
        end
        // funct7=0000001 on R-type: MUL with the extension, otherwise illegal
        drive(1, 7'b0110011, 3'd0, 7'h01, 0, 0);
        tick();
        n_cmp++;
        if (obs_word() !== m_ex) begin
            n_bad++; $display("FAIL r_funct7_01: got %h want %h", obs_word(), m_ex);
        end
        drive(0, 7'b0, 3'd0, 7'h00, 0, 0);
        for (int i = 0; i < MUL_LAT + 1; i++) tick();
    endtask

    task automatic test_stall_flush();
        drive(1, 7'b0000011, 3'd2, 7'h00, 0, 0);
        tick();
        drive(1, 7'b0110011, 3'd7, 7'h00, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({ex_valid, ex_mem_read, ex_mem_to_reg, ex_reg_write} !== 4'b1111 || obs_word() !== m_ex) begin
                n_bad++; $display("FAIL stall_hold_load[%0d]: got %h want %h", i, obs_word(), m_ex);
            end
        end
        drive(1, 7'b0110011, 3'd7, 7'h00, 0, 0);
        tick();
        n_cmp++;
        if ({ex_valid, ex_mem_read, ex_alu_control} !== {2'b10, 5'd2}) begin
            n_bad++; $display("FAIL stall_release_capture: got %h want AND word", obs_word());
        end
        drive(1, 7'b0110111, 3'd0, 7'h00, 1, 1);
        tick();
        n_cmp++;
        if (obs_word() !== 16'h0) begin
            n_bad++; $display("FAIL stall_flush_bubble: got %h want 0000", obs_word());
        end
    endtask

`ifdef RV32M_EN
    task automatic test_div_latency();
        int busy_n = 0, stall_n = 0, alu_bad = 0, guard = 0;
        drive(1, 7'b0110011, 3'd4, 7'h01, 0, 0);
        n_cmp++;
        if (id_stall_req !== 1'b1) begin
            n_bad++; $display("FAIL div_capture_stall_req: got %b want 1", id_stall_req);
        end
        tick();
        drive(0, 7'b0, 3'd0, 7'h00, 0, 0);
        while (muldiv_busy === 1'b1 && guard < 100) begin
            busy_n++;
            if (id_stall_req === 1'b1) stall_n++;
            if (ex_alu_control !== 5'd20 || ex_valid !== 1'b1) alu_bad++;
            tick();
            guard++;
        end
        n_cmp++;
        if (busy_n != DIV_LAT || guard >= 100) begin
            n_bad++; $display("FAIL div_busy_cycles: got %0d want %0d", busy_n, DIV_LAT);
        end
        n_cmp++;
        if (stall_n != DIV_LAT - 1) begin
            n_bad++; $display("FAIL div_stall_cycles: got %0d want %0d", stall_n, DIV_LAT - 1);
        end
        n_cmp++;
        if (alu_bad != 0) begin
            n_bad++; $display("FAIL div_alu_held: got %0d bad cycles want 0", alu_bad);
        end
        n_cmp++;
        if (obs_word() !== m_ex || m_occ != 0) begin
            n_bad++; $display("FAIL div_exit: got %h want %h", obs_word(), m_ex);
        end
    endtask

    task automatic test_mul_flush();
        drive(1, 7'b0110011, 3'd0, 7'h01, 0, 0);
        tick();
        drive(1, 7'b0110011, 3'd0, 7'h00, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({muldiv_busy, ex_valid, ex_alu_control, id_stall_req} !== {2'b11, 5'd16, (c < 3)}) begin
                n_bad++; $display("FAIL mul_busy_cycle%0d: got b/v/alu/sr %b/%b/%0d/%b want 1/1/16/%b",
                                  c, muldiv_busy, ex_valid, ex_alu_control, id_stall_req, c < 3);
            end
            if (c == 2) drive(1, 7'b0110011, 3'd0, 7'h00, 0, 1);
            else drive(1, 7'b0110011, 3'd0, 7'h00, 0, 0);
            tick();
        end
        n_cmp++;
        if ({muldiv_busy, obs_word()} !== 17'h0) begin
            n_bad++; $display("FAIL mul_post_flush_bubble: got %b/%h want 0/0000", muldiv_busy, obs_word());
        end
        tick();
        n_cmp++;
        if ({ex_valid, ex_reg_write, ex_alu_control} !== {2'b11, 5'd0} || obs_word() !== m_ex) begin
            n_bad++; $display("FAIL mul_pending_cleared: got %h want %h", obs_word(), m_ex);
        end
    endtask

    task automatic test_reset_mid_div();
        int guard = 0;
        drive(1, 7'b0110011, 3'd5, 7'h01, 0, 0);
        tick();
        drive(0, 7'b0, 3'd0, 7'h00, 0, 0);
        // DUT counter equals remaining busy cycles minus one
        while (m_occ != 21 && guard < 50) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        m_ex = '0; m_occ = 0; m_pend = 0;
        #1;
        n_cmp++;
        if ({muldiv_busy, id_stall_req, obs_word()} !== 18'h0 || guard >= 50) begin
            n_bad++; $display("FAIL reset_mid_div_async: got %b/%b/%h want 0/0/0000",
                              muldiv_busy, id_stall_req, obs_word());
        end
        tick();
        rst = 1'b0;
        drive(1, 7'b0110011, 3'd6, 7'h00, 0, 0);
        n_cmp++;
        if ({muldiv_busy, id_stall_req} !== 2'b00) begin
            n_bad++; $display("FAIL reset_mid_div_idle: got %b want 00", {muldiv_busy, id_stall_req});
        end
        tick();
        n_cmp++;
        if (obs_word() !== m_ex || ex_alu_control !== 5'd3) begin
            n_bad++; $display("FAIL reset_mid_div_capture: got %h want %h", obs_word(), m_ex);
        end
    endtask
`endif

    task automatic test_random();
        int k;
        logic [6:0] op, f7;
        for (int n = 0; n < 250; n++) begin
            k  = $urandom_range(0, 11);
            op = (k < 9) ? ops[k] : 7'($urandom);
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            drive($urandom_range(0, 5) != 0, op, 3'($urandom), f7,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            n_cmp++;
            if (id_stall_req !== exp_stall_req()) begin
                n_bad++; $display("FAIL rand_stall_req[%0d]: got %b want %b", n, id_stall_req, exp_stall_req());
            end
            tick();
            n_cmp++;
            if (obs_word() !== m_ex) begin
                n_bad++; $display("FAIL rand_bundle[%0d]: got %h want %h", n, obs_word(), m_ex);
            end
            n_cmp++;
            if (muldiv_busy !== (m_occ > 0)) begin
                n_bad++; $display("FAIL rand_busy[%0d]: got %b want %b", n, muldiv_busy, m_occ > 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add_sub();
        test_illegal();
        test_stall_flush();
`ifdef RV32M_EN
        test_div_latency();
        test_mul_flush();
        test_reset_mid_div();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
